// File: rtl/sram_ctr_ahb_addr_gen.sv
// rtl/sram_ctr_ahb_addr_gen.sv - AHB-Lite address-phase engine: SRAM word address, byte enables, strobes
// Sequential beats come from an internal byte-address register; SEQ haddr is only cross-checked.
module sram_ctr_ahb_addr_gen #(
  parameter int DATA_W    = 32,
  parameter int SRAM_AW   = 12,
  parameter int CHECK_SEQ = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic                  hready,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [31:0]           haddr,
  input  logic                  error_check,
  output logic [SRAM_AW-1:0]    sram_a,
  output logic [DATA_W/8-1:0]   sram_be,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  size_err,
  output logic                  seq_err
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = SRAM_AW + LB;
  localparam logic [2:0] LB3 = 3'(LB);

  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] baddr_q, baddr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [2:0]    size_q, size_d;
  logic [2:0]    burst_q, burst_d;
  logic [NB-1:0] be_d;
  logic          cs_d, we_d, size_err_d, seq_err_d;

  logic          acc, idle_beat, is_seq, new_xfer, bad_size, is_wrap, is_fixed;
  logic [2:0]    lg_n;
  logic [4:0]    len;
  logic [AW-1:0] step, next, wmask, pred;
  logic          unused_haddr;

  assign unused_haddr = ^haddr[31:AW];
  assign sram_a       = baddr_q[AW-1:LB];

  function automatic logic [NB-1:0] lane_mask(input logic [AW-1:0] a, input logic [2:0] sz);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = ((i >> sz) == (int'(a[LB-1:0]) >> sz));
    return m;
  endfunction

  // WRAPn boundary is n beats of the latched size; n = 4/8/16 maps to hburst[2:1] + 1 as a shift
  always_comb begin
    acc       = hsel & hready & htrans[1] & ~error_check;
    idle_beat = hsel & hready & ~error_check & (htrans == 2'b00);
    is_seq    = htrans[0];
    new_xfer  = ~is_seq | (state_q == S_IDLE);
    bad_size  = hsize > LB3;
    is_fixed  = burst_q[2:1] != 2'b00;
    is_wrap   = is_fixed & ~burst_q[0];
    lg_n      = {1'b0, burst_q[2:1]} + 3'd1;
    len       = 5'd1 << lg_n;
    step      = AW'(1) << size_q;
    next      = baddr_q + step;
    wmask     = (step << lg_n) - AW'(1);
    pred      = is_wrap ? ((baddr_q & ~wmask) | (next & wmask)) : next;
  end

  always_comb begin
    state_d    = state_q;
    baddr_d    = baddr_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    burst_d    = burst_q;
    be_d       = '0;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    size_err_d = 1'b0;
    seq_err_d  = 1'b0;
    if (acc) begin
      if (bad_size) begin
        size_err_d = 1'b1;
      end else if (new_xfer) begin
        // a SEQ arriving outside a burst restarts as a NONSEQ SINGLE
        baddr_d   = haddr[AW-1:0];
        cnt_d     = 5'd1;
        size_d    = hsize;
        burst_d   = is_seq ? 3'b000 : hburst;
        state_d   = (is_seq || hburst == 3'b000) ? S_IDLE : S_BURST;
        seq_err_d = (CHECK_SEQ != 0) && is_seq;
        cs_d      = 1'b1;
        we_d      = hwrite;
        be_d      = lane_mask(haddr[AW-1:0], hsize);
      end else begin
        baddr_d   = pred;
        cnt_d     = cnt_q + 5'd1;
        if (is_fixed && (cnt_q + 5'd1 == len)) state_d = S_IDLE;
        seq_err_d = (CHECK_SEQ != 0) && (haddr[AW-1:0] != pred);
        cs_d      = 1'b1;
        we_d      = hwrite;
        be_d      = lane_mask(pred, size_q);
      end
    end else if (idle_beat) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      baddr_q  <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      sram_be  <= '0;
      sram_cs  <= 1'b0;
      sram_we  <= 1'b0;
      size_err <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baddr_q  <= baddr_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      sram_be  <= be_d;
      sram_cs  <= cs_d;
      sram_we  <= we_d;
      size_err <= size_err_d;
      seq_err  <= seq_err_d;
    end
  end
endmodule

// File: doc/sram_ctr_ahb_addr_gen.md
Name: sram_ctr_ahb_addr_gen

Overview:
Parametrised AHB-Lite address-phase engine for the single-port SRAM controller. It captures each qualified AHB address phase and generates the SRAM word address, byte enables and strobes. Sequential beats are computed from an internal byte-address register; INCR and WRAP are sized by hsize, and the SRAM data width is configurable. It also flags illegal sizes and checks each SEQ haddr against the predicted address. Sits between the AHB slave interface and the SRAM macro; the write-data path consumes its registered outputs one cycle later.

Parameters:
DATA_W, 32, SRAM data width in bits; legal values 32 and 64; NB = DATA_W/8 byte lanes, LB = log2(NB)
SRAM_AW, 12, SRAM word-address width
CHECK_SEQ, 1, when 1 enables SEQ address-mismatch detection

Ports:
hclk  input  1  AHB clock
hresetn  input  1  asynchronous active-low reset
hsel  input  1  slave select
hready  input  1  bus ready; the address phase is accepted only when high
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hburst  input  3  SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16 (000..111)
hsize  input  3  transfer size; 0=byte, 1=half, 2=word, 3=dword
hwrite  input  1  write when 1
haddr  input  32  byte address
error_check  input  1  1 = current transfer is being error-responded; suppresses capture
sram_a  output  SRAM_AW  registered SRAM word address
sram_be  output  NB  registered byte enables
sram_cs  output  1  registered chip select, high for one cycle per accepted beat
sram_we  output  1  registered write strobe (sram_cs & hwrite)
size_err  output  1  registered, one-cycle pulse: accepted beat with hsize > LB
seq_err  output  1  registered, one-cycle pulse: SEQ haddr differs from predicted address

Behaviour:
- Clock and reset: a single clock, hclk. Reset is asynchronous and active-low on hresetn; polarity and synchronicity are fixed.
- Reset: baddr=0, sram_a=0, sram_be=0, sram_cs=0, sram_we=0, size_err=0, seq_err=0; FSM=IDLE.
- Internal byte-address register: baddr, width SRAM_AW+LB; sram_a = baddr[SRAM_AW+LB-1:LB].
- Accept condition: acc = hsel & hready & htrans[1] & ~error_check. Outputs update on the hclk edge after acc, so address-phase-to-SRAM latency is 1 cycle.
- If acc is false: sram_cs, sram_we, size_err and seq_err go to 0; baddr and sram_a hold.
- htrans=BUSY: baddr holds and the FSM holds; the next SEQ continues from the held address.
- FSM states:
  - IDLE -> BURST on an accepted NONSEQ when hburst != SINGLE.
  - BURST -> IDLE on an accepted NONSEQ with SINGLE.
  - BURST -> IDLE on an accepted beat with htrans=IDLE.
  - BURST -> IDLE when the beat counter reaches its length (4/8/16) for fixed bursts.
  - BURST -> BURST on a NONSEQ with a non-SINGLE burst; the counter reloads.
  - INCR (undefined length) stays in BURST until NONSEQ or IDLE.
- NONSEQ: baddr <= haddr[SRAM_AW+LB-1:0]; beat counter <= 1; size and burst are latched.
- SEQ: step = 1<<size_latched and next = baddr + step.
  - INCR*: baddr <= next; wraps modulo 2^(SRAM_AW+LB) at the top of the SRAM.
  - WRAPn: boundary B = n*step bytes; baddr <= (baddr & ~(B-1)) | (next & (B-1)).
- SEQ received while in IDLE (protocol violation): treated as NONSEQ SINGLE, and seq_err pulses.
- seq_err (CHECK_SEQ=1): asserted when an accepted SEQ has haddr[SRAM_AW+LB-1:0] != the predicted next address. The predicted address is still used.
- sram_be: one bit per byte; ones over bytes baddr[LB-1:0] .. +step-1, aligned down to step.
- Illegal size (hsize > LB): size_err=1, sram_cs=0, sram_be=0, baddr not updated.
- error_check high: acc is blocked; baddr, FSM and counter hold.
- Reset mid-burst clears everything immediately; no SRAM strobe is emitted after hresetn falls.

Test Plan:
- DATA_W=32: NONSEQ INCR4 word, haddr=0x0000_0010, then 3 SEQ -> sram_a 4,5,6,7; sram_be=1111; sram_cs high 4 cycles; FSM back to IDLE.
- WRAP4 word at haddr=0x38 -> sram_a 0xE,0xF,0xC,0xD.
- WRAP8 halfword at haddr=0x0C -> byte addresses 0x0C,0x0E,0x00,0x02,…; sram_be alternates 0011/1100.
- INCR byte burst, haddr=0x3FFF, then SEQ -> baddr wraps to 0x0000; sram_a 0xFFF->0x000; sram_be 1000->0001.
- BUSY mid-INCR8 for 2 cycles, plus error_check high for 1 cycle -> sram_cs low, sram_a held; resumes at the next address with no skipped beats.
- hsize=3 at DATA_W=32 -> size_err pulse, no sram_cs. SEQ with a wrong haddr -> seq_err pulse while the predicted sram_a is used. hresetn low mid-burst -> all outputs 0 asynchronously.
